// File: rtl/handshake_rr_arbiter.sv
// -----------------------------------------------------------------------------
// handshake_rr_arbiter
//   Round-robin arbiter merging N_REQ ready/valid requesters onto a single
//   downstream ready/valid channel through one registered output slot. Each
//   beat is tagged with the index of the requester that sourced it.
//
// Ports
//   CLK        in   clock, all state updates on posedge
//   RESET      in   synchronous active-high reset
//   req_valid  in   per-requester valid
//   req_ready  out  per-requester ready (one-hot or zero)
//   req_data   in   payloads, requester k at [k*DATA_W +: DATA_W]
//   out_valid  out  output slot holds a beat
//   out_ready  in   downstream accepts the beat
//   out_data   out  beat payload
//   out_src    out  index of the requester that sourced out_data
//   busy       out  out_valid | (|req_valid), forced low during reset
// -----------------------------------------------------------------------------
module handshake_rr_arbiter #(
   parameter  int N_REQ  = 3,
   parameter  int DATA_W = 5,
   localparam int IDX_W  = $clog2(N_REQ)
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic [N_REQ-1:0]          req_valid,
   output logic [N_REQ-1:0]          req_ready,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_W-1:0]         out_data,
   output logic [IDX_W-1:0]          out_src,
   output logic                      busy
);

   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q,  out_data_d;
   logic [IDX_W-1:0]  out_src_q,   out_src_d;
   logic [IDX_W-1:0]  last_grant_q, last_grant_d;

   logic              slot_free_s;
   logic              found_s;
   logic [IDX_W-1:0]  winner_s;
   logic              accept_s;

   // Slot can take a new beat when empty or when its current beat leaves this cycle.
   assign slot_free_s = !out_valid_q | out_ready;

   // Rotating priority search starting just after the last granted requester.
   always_comb begin
      int cand;
      found_s  = 1'b0;
      winner_s = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         cand = int'(last_grant_q) + i;
         if (cand >= N_REQ) begin
            cand = cand - N_REQ;
         end else begin
            cand = cand;
         end
         if (!found_s && req_valid[IDX_W'(cand)]) begin
            found_s  = 1'b1;
            winner_s = IDX_W'(cand);
         end else begin
            found_s  = found_s;
         end
      end
   end

   // The grant depends only on valids, slot state and reset, never on payload.
   assign accept_s = found_s & slot_free_s & !RESET;

   // One-hot ready towards the winning requester.
   always_comb begin
      req_ready = '0;
      if (accept_s) begin
         req_ready[winner_s] = 1'b1;
      end else begin
         req_ready = '0;
      end
   end

   // Next-state for the output slot and the round-robin pointer.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_src_d    = out_src_q;
      last_grant_d = last_grant_q;
      if (accept_s) begin
         // A new beat overwrites a draining one in the same cycle: no bubble.
         out_valid_d  = 1'b1;
         out_data_d   = req_data[int'(winner_s)*DATA_W +: DATA_W];
         out_src_d    = winner_s;
         last_grant_d = winner_s;
      end else if (out_valid_q && out_ready) begin
         out_valid_d  = 1'b0;
      end else begin
         out_valid_d  = out_valid_q;
      end
   end

   // State registers; the pointer resets to the last index so requester 0 wins first.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_src_q    <= '0;
         last_grant_q <= IDX_W'(N_REQ - 1);
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_src_q    <= out_src_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;
   assign busy      = !RESET & (out_valid_q | (|req_valid));

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
module tb_handshake_rr_arbiter;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [2:0]  req_valid;
   logic [2:0]  req_ready;
   logic [14:0] req_data;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_data;
   logic [1:0]  out_src;
   logic        busy;

   int checks = 0;
   int errors = 0;

   logic        stall_prev = 1'b0;
   logic [4:0]  data_prev  = 5'h00;

   handshake_rr_arbiter #(.N_REQ(3), .DATA_W(5)) dut (
      .CLK(CLK), .RESET(RESET),
      .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_src(out_src), .busy(busy)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Capture whether the cycle ending at this edge was a stall.
   always @(posedge CLK) begin
      stall_prev = out_valid & !out_ready & !RESET;
      data_prev  = out_data;
   end

   // Every-cycle protocol properties.
   always @(negedge CLK) begin
      if (RESET !== 1'b1 && RESET !== 1'b0) begin
         stall_prev = 1'b0;
      end else begin
         checks++;
         assert ($onehot0(req_ready)) else begin
            errors++;
            $error("FAIL onehot_ready: observed %b expected at most one bit", req_ready);
         end
         if (stall_prev) begin
            checks++;
            assert (out_data === data_prev) else begin
               errors++;
               $error("FAIL stall_stable: observed %0h expected %0h", out_data, data_prev);
            end
         end
      end
   end

   initial begin
      // ---------------- 1: reset state ----------------
      RESET = 1'b1; req_valid = 3'b000; out_ready = 1'b0;
      req_data = {5'h03, 5'h02, 5'h01};
      tick(); tick();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  32'(out_data),  32'd0);
      chk("rst_out_src",   32'(out_src),   32'd0);
      req_valid = 3'b111; out_ready = 1'b1;
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      tick();
      chk("rst_hold_valid", 32'(out_valid), 32'd0);

      // ---------------- 3: all valid, rotation 0,1,2,0,1,2 ----------------
      RESET = 1'b0;
      #1;
      chk("t1_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 6; i++) begin
         chk("t3_ready", 32'(req_ready), 32'(3'b001 << (i % 3)));
         tick();
         chk("t3_valid", 32'(out_valid), 32'd1);
         chk("t3_src",   32'(out_src),   32'(i % 3));
         chk("t3_data",  32'(out_data),  32'((i % 3) + 1));
         #1;
      end

      // ---------------- 2: only req 1, back-to-back 0A,0B,0C ----------------
      req_valid = 3'b010;
      req_data  = {5'h00, 5'h0A, 5'h00};
      #1;
      chk("t2_ready", 32'(req_ready), 32'b010);
      tick();
      chk("t2_data0", 32'(out_data), 32'h0A);
      chk("t2_src0",  32'(out_src),  32'd1);
      req_data = {5'h00, 5'h0B, 5'h00};
      tick();
      chk("t2_data1", 32'(out_data), 32'h0B);
      chk("t2_valid1", 32'(out_valid), 32'd1);
      req_data = {5'h00, 5'h0C, 5'h00};
      tick();
      chk("t2_data2", 32'(out_data), 32'h0C);
      chk("t2_src2",  32'(out_src),  32'd1);
      req_valid = 3'b000;
      tick();
      chk("t2_drain_valid", 32'(out_valid), 32'd0);
      chk("t2_drain_data",  32'(out_data),  32'h0C);
      chk("t2_drain_src",   32'(out_src),   32'd1);
      chk("t2_idle_busy",   32'(busy),      32'd0);

      // ---------------- 4: stall with 15 in the slot ----------------
      req_valid = 3'b100;
      req_data  = {5'h15, 5'h00, 5'h00};
      out_ready = 1'b0;
      #1;
      chk("t4_fill_ready", 32'(req_ready), 32'b100);
      tick();
      chk("t4_fill_data", 32'(out_data), 32'h15);
      chk("t4_fill_src",  32'(out_src),  32'd2);
      req_valid = 3'b111;
      req_data  = {5'h07, 5'h06, 5'h05};
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t4_stall_ready", 32'(req_ready), 32'd0);
         tick();
         chk("t4_stall_valid", 32'(out_valid), 32'd1);
         chk("t4_stall_data",  32'(out_data),  32'h15);
         chk("t4_stall_src",   32'(out_src),   32'd2);
      end
      out_ready = 1'b1;
      #1;
      chk("t4_release_ready", 32'(req_ready), 32'b001);
      tick();
      chk("t4_release_src",  32'(out_src),  32'd0);
      chk("t4_release_data", 32'(out_data), 32'h05);
      req_valid = 3'b000;
      tick();
      chk("t4_drain_valid", 32'(out_valid), 32'd0);

      // ---------------- 5: valid 101 with last_grant=0 ----------------
      req_valid = 3'b101;
      req_data  = {5'h13, 5'h12, 5'h11};
      #1;
      chk("t5_ready0", 32'(req_ready), 32'b100);
      tick();
      chk("t5_src0",  32'(out_src),  32'd2);
      chk("t5_data0", 32'(out_data), 32'h13);
      chk("t5_ready1", 32'(req_ready), 32'b001);
      tick();
      chk("t5_src1",  32'(out_src),  32'd0);
      chk("t5_data1", 32'(out_data), 32'h11);
      chk("t5_ready2", 32'(req_ready), 32'b100);

      // ---------------- 6: reset while holding a stalled beat ----------------
      req_valid = 3'b000;
      out_ready = 1'b0;
      tick();
      chk("t6_stall_valid", 32'(out_valid), 32'd1);
      chk("t6_stall_src",   32'(out_src),   32'd0);
      RESET = 1'b1;
      #1;
      chk("t6_rst_busy", 32'(busy), 32'd0);
      tick();
      chk("t6_lost_valid", 32'(out_valid), 32'd0);
      chk("t6_lost_data",  32'(out_data),  32'd0);
      RESET = 1'b0;
      req_valid = 3'b111;
      out_ready = 1'b1;
      #1;
      chk("t6_restart_ready", 32'(req_ready), 32'b001);
      tick();
      chk("t6_restart_src",  32'(out_src),  32'd0);
      chk("t6_restart_data", 32'(out_data), 32'h11);

      req_valid = 3'b000;
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
